// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with runtime pattern load,
// overlap/non-overlap matching and a saturating match counter.
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             e,
    input  logic             en,
    input  logic             clr,
    input  logic             pat_ld,
    input  logic [PAT_W-1:0] pat_in,
    output logic             s,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    logic [PAT_W-1:0] pat_q, pat_d, hist_q, hist_d, hist_n;
    logic [FW-1:0]    fill_q, fill_d, fill_n;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_q, s_d, hit;

    assign s         = s_q;
    assign match_cnt = cnt_q;
    assign cnt_sat   = &cnt_q;

    always_comb begin
        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        s_d    = 1'b0;
        hist_n = {hist_q[PAT_W-2:0], e};
        fill_n = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        hit    = (fill_n == FULL) && (hist_n == pat_q);
        if (pat_ld) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (clr) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (en) begin
            hist_d = hist_n;
            // non-overlap mode forgets everything seen so far once a match fires
            fill_d = (hit && !OVERLAP) ? '0 : fill_n;
            s_d    = hit;
            cnt_d  = (hit && !cnt_sat) ? cnt_q + 1'b1 : cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            cnt_q  <= '0;
            s_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            s_q    <= s_d;
        end
    end
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed checks of three detector variants
// (overlap, non-overlap, 2-bit counter) driven from shared inputs.
module tb_seq_detector_param;
    logic       clk = 1'b0, rst_n = 1'b0, e = 1'b0, en = 1'b0, clr = 1'b0, pat_ld = 1'b0;
    logic [3:0] pat_in = 4'b0;
    logic       s0, s1, s2, sat0, sat1, sat2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    int         errs = 0, checks = 0;

    always #5 clk = ~clk;

    seq_detector_param u_ov (.clk(clk), .rst_n(rst_n), .e(e), .en(en), .clr(clr), .pat_ld(pat_ld),
                             .pat_in(pat_in), .s(s0), .match_cnt(cnt0), .cnt_sat(sat0));
    seq_detector_param #(.OVERLAP(1'b0)) u_no (.clk(clk), .rst_n(rst_n), .e(e), .en(en), .clr(clr),
                             .pat_ld(pat_ld), .pat_in(pat_in), .s(s1), .match_cnt(cnt1), .cnt_sat(sat1));
    seq_detector_param #(.CNT_W(2)) u_c2 (.clk(clk), .rst_n(rst_n), .e(e), .en(en), .clr(clr),
                             .pat_ld(pat_ld), .pat_in(pat_in), .s(s2), .match_cnt(cnt2), .cnt_sat(sat2));

    task automatic step(input logic b, input logic v);
        e = b; en = v;
        @(posedge clk); #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; en = 1'b0;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    task automatic do_load(input logic [3:0] p, input logic b);
        pat_ld = 1'b1; pat_in = p; e = b; en = 1'b1;
        @(posedge clk); #1;
        pat_ld = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (s0 !== 1'b0) begin errs++; $display("FAIL reset_s got %0b exp 0", s0); end
        checks++; if (cnt0 !== 8'd0) begin errs++; $display("FAIL reset_cnt got %0d exp 0", cnt0); end
        checks++; if (sat0 !== 1'b0 || sat2 !== 1'b0) begin errs++; $display("FAIL reset_sat got %0b/%0b exp 0/0", sat0, sat2); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] st = 4'b1101;
        for (int i = 3; i >= 0; i--) begin
            step(st[i], 1'b1);
            checks++; if (s0 !== (i == 0)) begin errs++; $display("FAIL t1_s bit%0d got %0b exp %0b", 4 - i, s0, i == 0); end
        end
        checks++; if (cnt0 !== 8'd1) begin errs++; $display("FAIL t1_cnt got %0d exp 1", cnt0); end
        step(1'b0, 1'b0);
        checks++; if (s0 !== 1'b0) begin errs++; $display("FAIL t1_pulse_width got %0b exp 0", s0); end
        do_clr();
        checks++; if (cnt0 !== 8'd0) begin errs++; $display("FAIL t1_clr got %0d exp 0", cnt0); end
    endtask

    task automatic test_overlap();
        logic [6:0] st = 7'b1101101, x_ov = 7'b0001001, x_no = 7'b0001000;
        for (int i = 6; i >= 0; i--) begin
            step(st[i], 1'b1);
            checks++; if (s0 !== x_ov[i]) begin errs++; $display("FAIL t2_ov_s bit%0d got %0b exp %0b", 7 - i, s0, x_ov[i]); end
            checks++; if (s1 !== x_no[i]) begin errs++; $display("FAIL t2_no_s bit%0d got %0b exp %0b", 7 - i, s1, x_no[i]); end
        end
        checks++; if (cnt0 !== 8'd2) begin errs++; $display("FAIL t2_ov_cnt got %0d exp 2", cnt0); end
        checks++; if (cnt1 !== 8'd1) begin errs++; $display("FAIL t2_no_cnt got %0d exp 1", cnt1); end
    endtask

    task automatic test_load();
        logic [3:0] st = 4'b0110, old = 4'b1101;
        do_load(4'b0110, 1'b1);
        checks++; if (s0 !== 1'b0 || cnt0 !== 8'd2) begin errs++; $display("FAIL t3_load got s=%0b cnt=%0d exp s=0 cnt=2", s0, cnt0); end
        for (int i = 3; i >= 0; i--) begin
            step(st[i], 1'b1);
            checks++; if (s0 !== (i == 0)) begin errs++; $display("FAIL t3_new_s bit%0d got %0b exp %0b", 4 - i, s0, i == 0); end
        end
        do_clr();
        for (int i = 3; i >= 0; i--) begin
            step(old[i], 1'b1);
            checks++; if (s0 !== 1'b0) begin errs++; $display("FAIL t3_old_s bit%0d got %0b exp 0", 4 - i, s0); end
        end
        step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
        do_load(4'b1101, 1'b0);
        checks++; if (s0 !== 1'b0 || cnt0 !== 8'd0) begin errs++; $display("FAIL t3_ld_wins got s=%0b cnt=%0d exp s=0 cnt=0", s0, cnt0); end
    endtask

    task automatic test_enable();
        step(1'b1, 1'b1); step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(i[0], 1'b0);
            checks++; if (s0 !== 1'b0) begin errs++; $display("FAIL t4_hold_s cyc%0d got %0b exp 0", i, s0); end
        end
        step(1'b0, 1'b1);
        checks++; if (s0 !== 1'b0) begin errs++; $display("FAIL t4_bit3_s got %0b exp 0", s0); end
        step(1'b1, 1'b1);
        checks++; if (s0 !== 1'b1 || cnt0 !== 8'd1) begin errs++; $display("FAIL t4_hit got s=%0b cnt=%0d exp s=1 cnt=1", s0, cnt0); end
    endtask

    task automatic test_saturate();
        logic [7:0] x_no = 8'b00010001;
        do_clr();
        do_load(4'b1111, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b1);
            checks++; if (s0 !== (i >= 4)) begin errs++; $display("FAIL t5_ov_s bit%0d got %0b exp %0b", i, s0, i >= 4); end
            checks++; if (s1 !== x_no[8 - i]) begin errs++; $display("FAIL t5_no_s bit%0d got %0b exp %0b", i, s1, x_no[8 - i]); end
            checks++; if (cnt2 !== 2'((i < 4) ? 0 : (i > 6) ? 3 : i - 3)) begin errs++; $display("FAIL t5_cnt2 bit%0d got %0d", i, cnt2); end
            checks++; if (sat2 !== (i >= 6)) begin errs++; $display("FAIL t5_sat2 bit%0d got %0b exp %0b", i, sat2, i >= 6); end
        end
        checks++; if (cnt0 !== 8'd5 || cnt1 !== 8'd2) begin errs++; $display("FAIL t5_cnt got %0d/%0d exp 5/2", cnt0, cnt1); end
        do_clr();
        checks++; if (cnt2 !== 2'd0 || sat2 !== 1'b0) begin errs++; $display("FAIL t5_clr got cnt=%0d sat=%0b exp 0/0", cnt2, sat2); end
        do_load(4'b1101, 1'b0);
    endtask

    task automatic test_async_reset();
        logic [3:0] st = 4'b1101;
        for (int i = 3; i >= 0; i--) step(st[i], 1'b1);
        checks++; if (s0 !== 1'b1) begin errs++; $display("FAIL t6_pre got %0b exp 1", s0); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (s0 !== 1'b0 || cnt0 !== 8'd0) begin errs++; $display("FAIL t6_async got s=%0b cnt=%0d exp 0/0", s0, cnt0); end
        @(posedge clk); #1 rst_n = 1'b1;
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
        #2 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        step(1'b1, 1'b1);
        checks++; if (s0 !== 1'b0) begin errs++; $display("FAIL t6_cut got %0b exp 0", s0); end
        for (int i = 3; i >= 0; i--) begin
            step(st[i], 1'b1);
            checks++; if (s0 !== (i == 0)) begin errs++; $display("FAIL t6_after bit%0d got %0b exp %0b", 4 - i, s0, i == 0); end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_overlap();
        test_load();
        test_enable();
        test_saturate();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
